mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that consumes the execute stage's `execute_data_t` bundle and is its downstream end. It issues loads and stores on the data bus with a valid/addr_ok/data_ok handshake, aligns and extends load data, and detects misaligned addresses. It holds one instruction at a time and presents a writeback-ready result through a valid/ready handshake toward writeback.

## Interface
Parameters: none (widths come from `common`: `word_t` 32 b, `creg_addr_t` 5 b).
- clk  in  1  stage clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard held/in-flight instruction (exception/eret redirect)
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept bundle this cycle
- in_data  in  execute_data_t  from execute: instr, aluout (address/result), writedata (store data), writereg, pcplus4, exception flags
- dreq_valid  out  1  data-bus request valid
- dreq_addr  out  32  byte address (= aluout)
- dreq_strobe  out  4  byte write enables; 0000 = read
- dreq_data  out  32  store data, lane-replicated
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response complete (read data valid)
- dresp_data  in  32  raw read word
- out_valid  out  1  result valid toward writeback
- out_ready  in  1  writeback accepts
- out_result  out  32  load value or aluout
- out_writereg  out  5  destination register, 0 = no write
- out_pcplus4  out  32  passthrough
- out_exc_adel / out_exc_ades  out  1  load/store address error
- out_badvaddr  out  32  faulting address, otherwise 0

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. `in_ready` = (IDLE) or (DONE and out_ready).
- On accept (`in_valid & in_ready`), the bundle is registered. The op class comes from `instr` (LB/LBU/LH/LHU/LW/SB/SH/SW; anything else is non-memory).
- Non-memory op, or incoming bundle already carrying an exception: go to DONE with `out_result` = aluout.
- Alignment check on accept: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, raises ADEL (load) or ADES (store). `badvaddr` = addr, `writereg` is forced to 0, no bus request is made, go to DONE.
- Otherwise go to REQ. `dreq_valid`=1 with addr/strobe/data held stable until addr_ok.
- Store strobe and data:
  - SB: strobe 0001<<addr[1:0], data = {4{byte}}.
  - SH: strobe 0011 (addr[1]=0) or 1100, data = {2{half}}.
  - SW: strobe 1111.
- REQ transitions on addr_ok: if data_ok is also high in the same cycle, go to DONE; otherwise go to WAIT. WAIT→DONE on data_ok.
- Load extract:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the full word.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - The result is captured in the data_ok cycle.
- Stores produce out_writereg=0.
- DONE: out_valid=1, outputs held until out_ready. On the handshake, a new bundle may be accepted in the same cycle (→ its next state); otherwise go to IDLE.
- Flush:
  - IDLE/DONE, or REQ without addr_ok this cycle → IDLE; the held instruction is dropped and dreq_valid drops next cycle.
  - WAIT, or REQ with addr_ok this cycle → DRAIN. DRAIN waits for data_ok, discards it, then → IDLE. in_ready=0 and out_valid=0 in DRAIN.
  - A flush also blocks the accept in that cycle.

## Timing
- Reset (async assert, sync deassert): state IDLE, out_valid 0, dreq_valid 0, dreq_strobe 0000, dreq_addr/data 0, all out_* 0; in_ready=1 after reset.
- Latency, accept→out_valid:
  - Non-memory or exception: 1 cycle.
  - Memory with addr_ok and data_ok in the first REQ cycle: 2 cycles.
  - Each stalled bus cycle adds 1.
- dreq_* registered; never change while dreq_valid=1 and addr_ok=0.
- Throughput: 1 instr/cycle for non-memory ops under continuous out_ready.
- No more than one outstanding bus transaction, including during DRAIN.
- Reset mid-transaction: returns to IDLE immediately; bus-side recovery is the bus master's responsibility.

## Test plan
- ALU bundle aluout=0x1234, writereg=8, out_ready=1 → out_valid next cycle, out_result=0x1234, out_writereg=8; back-to-back bundles stream at 1/cycle.
- LB addr=0x103, dresp_data=0x80FF_EE11 with addr_ok/data_ok on the first REQ cycle → out_result=0xFFFF_FF80; LBU → 0x0000_0080.
- SH addr=0x102, writedata=0xAAAA_BEEF → dreq_strobe=1100, dreq_data=0xBEEF_BEEF; addr_ok after 3 stall cycles → addr held stable, out_writereg=0.
- LW addr=0x101 → no dreq_valid, out_exc_adel=1, out_badvaddr=0x101, out_writereg=0; SW addr=0x102 → out_exc_ades=1.
- LW with addr_ok, flush asserted in WAIT, data_ok 2 cycles later → no out_valid, in_ready=0 until data_ok, then IDLE.
- Hold out_ready=0 for 4 cycles in DONE → outputs stable, in_ready=0; assert resetn=0 mid-WAIT → all outputs return to reset values.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : memory-access pipeline stage (load/store bus issue, align, extend)
// Rev 1.0
// ============================================================================
`default_nettype none

package common;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;
  typedef struct packed {
    word_t      instr;
    word_t      pcplus4;
    word_t      aluout;
    word_t      writedata;
    creg_addr_t writereg;
    logic       exc_adel_if;
    logic       exc_ri;
    logic       exc_ov;
  } execute_data_t;
endpackage

module mem_stage
  import common::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  execute_data_t in_data,
  output logic          dreq_valid,
  output logic [31:0]   dreq_addr,
  output logic [3:0]    dreq_strobe,
  output logic [31:0]   dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [31:0]   dresp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [4:0]    out_writereg,
  output logic [31:0]   out_pcplus4,
  output logic          out_exc_adel,
  output logic          out_exc_ades,
  output logic [31:0]   out_badvaddr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  logic [2:0]  state_q, state_d;
  logic        is_load_q, ld_sext_q;
  logic [1:0]  ld_size_q, addr_lo_q;
  logic [31:0] result_q, pcplus4_q, badvaddr_q;
  logic [4:0]  writereg_q;
  logic        adel_q, ades_q;
  logic        dreq_valid_q;
  logic [31:0] dreq_addr_q, dreq_data_q;
  logic [3:0]  dreq_strobe_q;

  logic [5:0]  opcode;
  logic [1:0]  a_lo;
  logic        is_load, is_store, sext, misalign, prior_exc, mem_go, accept, ld_capture;
  logic [1:0]  size;
  logic [3:0]  st_strobe;
  logic [31:0] st_data, load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [2:0]  accept_next;
  logic        unused_bits;

  assign opcode      = in_data.instr[31:26];
  assign a_lo        = in_data.aluout[1:0];
  assign unused_bits = ^in_data.instr[25:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size      = 2'd2;
    sext      = 1'b0;
    st_strobe = 4'b0000;
    st_data   = 32'h0;
    case (opcode)
      OP_LB:  begin is_load = 1'b1; size = 2'd0; sext = 1'b1; end
      OP_LBU: begin is_load = 1'b1; size = 2'd0; end
      OP_LH:  begin is_load = 1'b1; size = 2'd1; sext = 1'b1; end
      OP_LHU: begin is_load = 1'b1; size = 2'd1; end
      OP_LW:  begin is_load = 1'b1; end
      OP_SB: begin
        is_store  = 1'b1;
        size      = 2'd0;
        st_strobe = 4'b0001 << a_lo;
        st_data   = {4{in_data.writedata[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        size      = 2'd1;
        st_strobe = a_lo[1] ? 4'b1100 : 4'b0011;
        st_data   = {2{in_data.writedata[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        st_strobe = 4'b1111;
        st_data   = in_data.writedata;
      end
      default: ;
    endcase
  end

  // Alignment is only judged for memory ops that have not already faulted upstream.
  assign prior_exc   = in_data.exc_adel_if | in_data.exc_ri | in_data.exc_ov;
  assign misalign    = (is_load | is_store) & ~prior_exc &
                       (((size == 2'd1) & a_lo[0]) | ((size == 2'd2) & (a_lo != 2'b00)));
  assign mem_go      = (is_load | is_store) & ~prior_exc & ~misalign;
  assign accept_next = mem_go ? S_REQ : S_DONE;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = dresp_data[7:0];
      2'd1:    ld_byte = dresp_data[15:8];
      2'd2:    ld_byte = dresp_data[23:16];
      default: ld_byte = dresp_data[31:24];
    endcase
    ld_half = addr_lo_q[1] ? dresp_data[31:16] : dresp_data[15:0];
    case (ld_size_q)
      2'd0:    load_val = ld_sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'd1:    load_val = ld_sext_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: load_val = dresp_data;
    endcase
  end

  // A flush that coincides with the final data_ok has nothing left to drain.
  always_comb begin
    state_d    = state_q;
    ld_capture = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = accept_next;
      S_REQ: begin
        if (dresp_addr_ok) begin
          if (flush)              state_d = dresp_data_ok ? S_IDLE : S_DRAIN;
          else if (dresp_data_ok) begin state_d = S_DONE; ld_capture = 1'b1; end
          else                    state_d = S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dresp_data_ok) begin
          state_d    = flush ? S_IDLE : S_DONE;
          ld_capture = ~flush;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush)          state_d = S_IDLE;
        else if (out_ready) state_d = accept ? accept_next : S_IDLE;
      end
      S_DRAIN: if (dresp_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      is_load_q     <= 1'b0;
      ld_sext_q     <= 1'b0;
      ld_size_q     <= 2'd0;
      addr_lo_q     <= 2'd0;
      result_q      <= 32'h0;
      pcplus4_q     <= 32'h0;
      badvaddr_q    <= 32'h0;
      writereg_q    <= 5'd0;
      adel_q        <= 1'b0;
      ades_q        <= 1'b0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= 32'h0;
      dreq_data_q   <= 32'h0;
      dreq_strobe_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      dreq_valid_q <= (state_d == S_REQ);
      if (accept) begin
        is_load_q  <= is_load;
        ld_sext_q  <= sext;
        ld_size_q  <= size;
        addr_lo_q  <= a_lo;
        result_q   <= in_data.aluout;
        pcplus4_q  <= in_data.pcplus4;
        writereg_q <= (misalign | is_store) ? 5'd0 : in_data.writereg;
        adel_q     <= misalign & is_load;
        ades_q     <= misalign & is_store;
        badvaddr_q <= misalign ? in_data.aluout : 32'h0;
        if (mem_go) begin
          dreq_addr_q   <= in_data.aluout;
          dreq_strobe_q <= st_strobe;
          dreq_data_q   <= st_data;
        end
      end else if (ld_capture && is_load_q) begin
        result_q <= load_val;
      end
    end
  end

  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;
  assign out_valid    = (state_q == S_DONE);
  assign out_result   = result_q;
  assign out_writereg = writereg_q;
  assign out_pcplus4  = pcplus4_q;
  assign out_exc_adel = adel_q;
  assign out_exc_ades = ades_q;
  assign out_badvaddr = badvaddr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage with a scripted data-bus slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import common::*;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  execute_data_t in_data = '0;
  logic          dreq_valid;
  logic [31:0]   dreq_addr;
  logic [3:0]    dreq_strobe;
  logic [31:0]   dreq_data;
  logic          dresp_addr_ok = 1'b0;
  logic          dresp_data_ok = 1'b0;
  logic [31:0]   dresp_data = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic [4:0]    out_writereg;
  logic [31:0]   out_pcplus4;
  logic          out_exc_adel;
  logic          out_exc_ades;
  logic [31:0]   out_badvaddr;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_writereg(out_writereg), .out_pcplus4(out_pcplus4),
    .out_exc_adel(out_exc_adel), .out_exc_ades(out_exc_ades), .out_badvaddr(out_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  wreg;
    logic [31:0] pc;
    logic        adel;
    logic        ades;
    logic [31:0] bad;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } req_t;

  localparam logic [5:0] OP_ALU = 6'h00;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  exp_t        exp_q[$];
  req_t        req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          addr_stall = 0;
  int          data_gap = 0;
  int          cyc = 0;
  logic [31:0] pc = 32'h0040_0004;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output scoreboard: every writeback handshake must match the oldest expectation.
  initial begin : monitor
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        got = {out_result, out_writereg, out_pcplus4, out_exc_adel, out_exc_ades, out_badvaddr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got result=%h wreg=%0d", got.result, got.wreg);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_bundle got res=%h wreg=%0d pc=%h adel=%b ades=%b bad=%h exp res=%h wreg=%0d pc=%h adel=%b ades=%b bad=%h",
                     got.result, got.wreg, got.pc, got.adel, got.ades, got.bad,
                     e.result, e.wreg, e.pc, e.adel, e.ades, e.bad);
          end
        end
      end
    end
  end

  // Data-bus slave: addr_ok after addr_stall waiting cycles, data_ok data_gap cycles later.
  initial begin : bus
    req_t r, got;
    bit   pending;
    int   acnt, dcnt;
    pending = 0; acnt = 0; dcnt = 0;
    forever begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      if (!resetn) begin
        pending = 0;
        acnt    = 0;
      end else if (pending) begin
        if (dcnt == 0) begin dresp_data_ok = 1'b1; pending = 0; end
        else dcnt--;
      end else if (dreq_valid) begin
        if (acnt < addr_stall) acnt++;
        else begin
          acnt = 0;
          dresp_addr_ok = 1'b1;
          if (data_gap == 0) dresp_data_ok = 1'b1;
          else begin pending = 1; dcnt = data_gap - 1; end
          got = {dreq_addr, dreq_strobe, dreq_data};
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected addr=%h strobe=%b", got.addr, got.strobe);
          end else begin
            r = req_q.pop_front();
            if (got.addr !== r.addr || got.strobe !== r.strobe || (r.strobe != 4'b0 && got.data !== r.data)) begin
              errors++;
              $display("FAIL bus_req got addr=%h strobe=%b data=%h exp addr=%h strobe=%b data=%h",
                       got.addr, got.strobe, got.data, r.addr, r.strobe, r.data);
            end
          end
        end
      end
    end
  end

  task automatic expect_out(input logic [31:0] res, input logic [4:0] wreg,
                            input logic adel, input logic ades, input logic [31:0] bad);
    exp_t e;
    e = {res, wreg, pc, adel, ades, bad};
    exp_q.push_back(e);
  endtask

  task automatic expect_req(input logic [31:0] addr, input logic [3:0] strobe, input logic [31:0] data);
    req_t r;
    r = {addr, strobe, data};
    req_q.push_back(r);
  endtask

  // Presents one bundle and returns at #1 after the edge that accepted it.
  task automatic send(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [4:0] wr, input logic [2:0] exc);
    bit ok;
    in_data.instr     = {op, 26'h0};
    in_data.pcplus4   = pc;
    in_data.aluout    = alu;
    in_data.writedata = wd;
    in_data.writereg  = wr;
    {in_data.exc_adel_if, in_data.exc_ri, in_data.exc_ov} = exc;
    in_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready && !flush) ok = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    pc = pc + 32'd4;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept got in_ready=%b exp 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && (exp_q.size() != 0 || req_q.size() != 0); n++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending out=%0d req=%0d exp 0", exp_q.size(), req_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_result, out_writereg, out_pcplus4, out_exc_adel, out_exc_ades, out_badvaddr} !== '0) begin
      errors++;
      $display("FAIL reset_out got res=%h wreg=%0d bad=%h exp all 0", out_result, out_writereg, out_badvaddr);
    end
    checks++;
    if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_dreq got valid=%b addr=%h strobe=%b out_valid=%b exp 0", dreq_valid, dreq_addr, dreq_strobe, out_valid);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    expect_out(32'h1234, 5'd8, 1'b0, 1'b0, 32'h0);
    send(OP_ALU, 32'h1234, 32'h0, 5'd8, 3'b000);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency got out_valid=%b exp 1", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      expect_out(32'h100 + i, 5'(i + 1), 1'b0, 1'b0, 32'h0);
      send(OP_ALU, 32'h100 + i, 32'h0, 5'(i + 1), 3'b000);
    end
    checks++;
    if (cyc - t0 !== 4) begin
      errors++;
      $display("FAIL b2b_rate got %0d cycles exp 4", cyc - t0);
    end
    wait_drain();
  endtask

  task automatic test_load_ext();
    logic [5:0]  ops[6];
    logic [31:0] adr[6];
    logic [31:0] res[6];
    ops = '{OP_LB, OP_LBU, OP_LB, OP_LH, OP_LHU, OP_LW};
    adr = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h100, 32'h104};
    res = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0011, 32'hFFFF_80FF, 32'h0000_EE11, 32'h80FF_EE11};
    dresp_data = 32'h80FF_EE11;
    addr_stall = 0;
    data_gap   = 0;
    for (int i = 0; i < 6; i++) begin
      expect_req(adr[i], 4'b0000, 32'h0);
      expect_out(res[i], 5'd9, 1'b0, 1'b0, 32'h0);
      send(ops[i], adr[i], 32'h0, 5'd9, 3'b000);
      checks++;
      if (out_valid !== 1'b0 || dreq_valid !== 1'b1) begin
        errors++;
        $display("FAIL load_req_cycle got out_valid=%b dreq_valid=%b exp 0/1", out_valid, dreq_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL load_latency got out_valid=%b exp 1", out_valid);
      end
      wait_drain();
    end
  endtask

  task automatic test_store_stall();
    addr_stall = 3;
    data_gap   = 0;
    expect_req(32'h102, 4'b1100, 32'hBEEF_BEEF);
    expect_out(32'h102, 5'd0, 1'b0, 1'b0, 32'h0);
    send(OP_SH, 32'h102, 32'hAAAA_BEEF, 5'd12, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dreq_valid !== 1'b1 || dreq_addr !== 32'h102 || dreq_strobe !== 4'b1100 || dreq_data !== 32'hBEEF_BEEF) begin
        errors++;
        $display("FAIL store_hold got valid=%b addr=%h strobe=%b data=%h exp 1/102/1100/beefbeef",
                 dreq_valid, dreq_addr, dreq_strobe, dreq_data);
      end
    end
    wait_drain();
    addr_stall = 1;
    expect_req(32'h101, 4'b0010, 32'h5A5A_5A5A);
    expect_out(32'h101, 5'd0, 1'b0, 1'b0, 32'h0);
    send(OP_SB, 32'h101, 32'h1234_565A, 5'd13, 3'b000);
    wait_drain();
    expect_req(32'h104, 4'b1111, 32'hDEAD_BEEF);
    expect_out(32'h104, 5'd0, 1'b0, 1'b0, 32'h0);
    send(OP_SW, 32'h104, 32'hDEAD_BEEF, 5'd14, 3'b000);
    wait_drain();
    addr_stall = 0;
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops[4];
    logic [31:0] adr[4];
    logic        ld[4];
    ops = '{OP_LW, OP_SW, OP_LH, OP_SH};
    adr = '{32'h101, 32'h102, 32'h103, 32'h101};
    ld  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      expect_out(adr[i], 5'd0, ld[i], !ld[i], adr[i]);
      send(ops[i], adr[i], 32'h0, 5'd7, 3'b000);
      checks++;
      if (out_valid !== 1'b1 || dreq_valid !== 1'b0) begin
        errors++;
        $display("FAIL misalign_latency got out_valid=%b dreq_valid=%b exp 1/0", out_valid, dreq_valid);
      end
      wait_drain();
    end
    // Upstream fault on an aligned load: no bus traffic, fields pass through.
    expect_out(32'h200, 5'd6, 1'b0, 1'b0, 32'h0);
    send(OP_LW, 32'h200, 32'h0, 5'd6, 3'b010);
    wait_drain();
  endtask

  task automatic test_flush_drain();
    bit saw;
    addr_stall = 0;
    data_gap   = 3;
    expect_req(32'h200, 4'b0000, 32'h0);
    send(OP_LW, 32'h200, 32'h0, 5'd4, 3'b000);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    saw = 0;
    for (int n = 0; n < 20 && !saw; n++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold got in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
      end
      if (dresp_data_ok) saw = 1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!saw || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit got saw_data_ok=%b in_ready=%b out_valid=%b exp 1/1/0", saw, in_ready, out_valid);
    end
    data_gap = 0;
    wait_drain();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    expect_out(32'hCAFE, 5'd3, 1'b0, 1'b0, 32'h0);
    send(OP_ALU, 32'hCAFE, 32'h0, 5'd3, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hCAFE || out_writereg !== 5'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable got valid=%b res=%h wreg=%0d in_ready=%b exp 1/cafe/3/0",
                 out_valid, out_result, out_writereg, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid_wait();
    data_gap = 5;
    expect_req(32'h300, 4'b0000, 32'h0);
    send(OP_LW, 32'h300, 32'h0, 5'd2, 3'b000);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({out_valid, dreq_valid, dreq_addr, dreq_strobe, dreq_data, out_result, out_writereg,
         out_pcplus4, out_exc_adel, out_exc_ades, out_badvaddr} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait got out_valid=%b dreq_valid=%b addr=%h res=%h in_ready=%b exp 0/0/0/0/1",
               out_valid, dreq_valid, dreq_addr, out_result, in_ready);
    end
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    data_gap = 0;
    expect_out(32'h77, 5'd5, 1'b0, 1'b0, 32'h0);
    send(OP_ALU, 32'h77, 32'h0, 5'd5, 3'b000);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_ext();
    test_store_stall();
    test_misaligned();
    test_flush_drain();
    test_hold();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
